// File: rtl/ara_inval_coalescer.sv
// Line-aligning, de-duplicating invalidation queue between Ara's write-path filter and CVA6.
// Requests that hit a queued line are merged; the entry being popped this cycle is excluded.
module ara_inval_coalescer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 empty_o,
    output logic                 coalesced_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineWidth - 1);

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [Depth-1:0]     vld_q;
    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q, rd_next, wr_next;
    logic [CntW-1:0]      count_q, count_d;
    logic [AddrWidth-1:0] head_q, head_d;
    logic                 empty_q, coal_q;

    logic [AddrWidth-1:0] line;
    logic                 pop, push, merge, match, full;

    assign line    = in_addr_i & LineMask;
    assign full    = (count_q == CntW'(Depth));
    assign pop     = (count_q != '0) && out_ready_i;
    assign rd_next = rd_ptr_q + PtrW'(1);
    assign wr_next = wr_ptr_q + PtrW'(1);

    // The head leaving this cycle is no longer a merge target: the new request must be re-queued.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (vld_q[i] && (mem_q[i] == line) && !(pop && (PtrW'(i) == rd_ptr_q))) begin
                match = 1'b1;
            end
        end
    end

    assign in_ready_o = !en_i || match || !full || pop;
    assign push       = en_i && in_valid_i && !match && (!full || pop);
    assign merge      = en_i && in_valid_i && match;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Head register is precomputed so out_addr_o never sees a combinational path from in_*.
    always_comb begin
        head_d = head_q;
        if (count_d == '0) begin
            head_d = '0;
        end else if (pop) begin
            head_d = (count_q == CntW'(1)) ? line : mem_q[rd_next];
        end else if (count_q == '0) begin
            head_d = line;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            coal_q   <= 1'b0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_next;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= line;
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_next;
            end
            count_q <= count_d;
            head_q  <= head_d;
            empty_q <= (count_d == '0);
            coal_q  <= merge;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_addr_o  = head_q;
    assign empty_o     = empty_q;
    assign coalesced_o = coal_q;

`ifndef SYNTHESIS
    logic dup;
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            for (int j = i + 1; j < Depth; j++) begin
                if (vld_q[i] && vld_q[j] && (mem_q[i] == mem_q[j])) begin
                    dup = 1'b1;
                end
            end
        end
    end

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && (count_q == '0)));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full && !pop));
    a_out_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o |-> ((out_addr_o & ~LineMask) == '0));
    a_no_dup: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup);
`endif

endmodule

// File: doc/ara_inval_coalescer.md
Name: ara_inval_coalescer

Overview:
- Buffers and de-duplicates L1 data-cache invalidation requests on their way to the CVA6 accelerator-response port.
- Sits downstream of the AXI invalidation filter on Ara's write path, consuming its inval_addr/inval_valid/inval_ready stream.
- Line-aligns each address and drops any request that hits a line already queued.
- Absorbs bursts of same-line vector stores while CVA6 is slow to accept invalidations.

Parameters:
- AddrWidth, 64, width of invalidation addresses.
- L1LineWidth, 16, L1 D-cache line size in bytes; power of two, at least 2.
- Depth, 4, number of queue entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  coherence enable (acc_cons_en). When low, incoming requests are discarded.
- in_addr_i  in  AddrWidth  invalidation byte address from the filter.
- in_valid_i  in  1  incoming request valid.
- in_ready_o  out  1  incoming request accepted.
- out_addr_o  out  AddrWidth  line-aligned address to CVA6; low log2(L1LineWidth) bits are always 0.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  CVA6 accepts the invalidation.
- empty_o  out  1  queue holds no entries.
- coalesced_o  out  1  single-cycle pulse when an accepted request is merged (dropped as a duplicate).

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset values: queue emptied, read/write pointers and count = 0, entry storage = 0. Hence out_valid_o = 0, out_addr_o = 0, empty_o = 1, coalesced_o = 0, in_ready_o = 1.
- Reset mid-operation: all queued entries are lost. No output is generated for them.
- Line alignment: line = in_addr_i with the low log2(L1LineWidth) bits cleared.
- Storage: circular FIFO of Depth line addresses plus one valid bit per entry. Count has width log2(Depth)+1.
- Output side:
  - out_valid_o = (count != 0); out_addr_o = head entry, driven from a register.
  - Pop occurs when out_valid_o && out_ready_i.
  - out_addr_o/out_valid_o stay stable while out_valid_o && !out_ready_i.
- Match detection:
  - match = line equals any valid entry, excluding the head entry when it pops in the same cycle.
  - A line that is being handed to CVA6 this cycle must be re-queued, not merged.
- Input side, en_i = 1:
  - match: in_ready_o = 1. The request is dropped and coalesced_o pulses the next cycle; no enqueue.
  - no match and (count < Depth or pop): in_ready_o = 1 and the request is enqueued at the tail.
  - no match, count = Depth, no pop: in_ready_o = 0 and the request is held upstream.
- Input side, en_i = 0: in_ready_o = 1; requests are dropped with no enqueue and no coalesced pulse. Queued entries still drain normally.
- Latency: a request enqueued in cycle N appears on out_valid_o/out_addr_o in cycle N+1 at the earliest. There is no combinational path from in_* to out_*.
- in_ready_o may depend combinationally on in_addr_i, en_i, out_ready_i and state. It must not depend on in_valid_i.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - When full, push plus pop is legal and the queue stays full.
  - When count = 1, the pushed entry becomes the head in the next cycle.
- Wrap-around: pointers wrap modulo Depth. full = (count == Depth).
- empty_o = (count == 0), driven from a register.
- Assertions (simulation only):
  - No pop when empty; no push when full without a pop.
  - out_addr_o is line-aligned whenever out_valid_o = 1.
  - No two valid entries hold the same line.

Test Plan:
- Reset, then idle: out_valid_o = 0, empty_o = 1, in_ready_o = 1 and out_addr_o = 0 on every cycle.
- Coalescing, out_ready_i = 0:
  - Push 0x8000_1004, then 0x8000_100C. Exactly one entry 0x8000_1000 is queued and coalesced_o pulses once.
  - Then push 0x8000_1010. A second entry 0x8000_1010 is queued.
  - Raise out_ready_i: outputs 0x8000_1000 then 0x8000_1010, then empty_o = 1.
- Full back-pressure, Depth = 4:
  - Push lines 0x000, 0x010, 0x020, 0x030 with out_ready_i = 0.
  - Presenting 0x040 gives in_ready_o = 0; presenting 0x024 gives in_ready_o = 1 and a merge.
  - Raising out_ready_i in the same cycle as the 0x040 push accepts 0x040, and count stays 4.
- Pop/push same line: head = 0x0A0 popping while in_addr_i = 0x0A8 is pushed. The request is enqueued (not merged), and 0x0A0 appears again as the next output after the remaining entries.
- en_i = 0 with 2 entries queued: pushes of 0x200 and 0x300 are accepted and dropped. The 2 old entries drain, then out_valid_o = 0.
- Reset asserted with 3 entries queued: outputs return to reset values asynchronously. After release, pushing 0x500 yields out_addr_o = 0x500 one cycle later.
